// File: rtl/mem_fu_responder.sv
// rtl/mem_fu_responder.sv - load/store functional-unit responder with two retire write ports
// Owns the word memory; loads return data after LOAD_LATENCY wait cycles, stores return their address.
module mem_fu_responder #(
   parameter int         MEM_WORDS    = 1024,
   parameter int         LOAD_LATENCY = 2,
   parameter int         TAG_W        = 6,
   parameter logic [2:0] OP_LOAD      = 3'd1,
   parameter logic [2:0] OP_STORE     = 3'd2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [2:0]       issue_op,
   input  logic [31:0]      issue_inp1,
   input  logic [31:0]      issue_inp2,
   input  logic [TAG_W-1:0] issue_tag,
   output logic             fu_ready,
   output logic             result_valid,
   output logic [31:0]      result_data,
   output logic [TAG_W-1:0] result_tag,
   input  logic [31:0]      write_address1,
   input  logic [31:0]      write_data1,
   input  logic             we1,
   input  logic [31:0]      write_address2,
   input  logic [31:0]      write_data2,
   input  logic             we2,
   output logic             oob_err,
   output logic             protocol_err
);
   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam int          CNT_W     = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
   localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);

   typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q;
   logic [TAG_W-1:0]   tag_q;
   logic [31:0]        base_q, off_q, ea_q, res_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               load_oob_q;
   logic [31:0]        mem [MEM_WORDS];

   logic [31:0]        ea, sample;
   logic               is_ls, ea_ok, wr1_ok, wr2_ok, wr_oob;
   logic [IDX_W-1:0]   ea_idx, idx1, idx2;

   function automatic logic in_range(input logic [31:0] addr);
      return {1'b0, addr} < MEM_BYTES;
   endfunction

   assign ea     = base_q + off_q;
   assign is_ls  = (op_q == OP_LOAD) || (op_q == OP_STORE);
   assign ea_ok  = in_range(ea_q);
   assign ea_idx = ea_q[IDX_W+1:2];
   assign idx1   = write_address1[IDX_W+1:2];
   assign idx2   = write_address2[IDX_W+1:2];
   assign wr1_ok = we1 && in_range(write_address1);
   assign wr2_ok = we2 && in_range(write_address2);
   assign wr_oob = (we1 && !in_range(write_address1)) || (we2 && !in_range(write_address2));

   // Write-first forwarding: a retire write in the sample cycle is seen by the load, port 2 last.
   always_comb begin
      sample = mem[ea_idx];
      if (wr1_ok && (idx1 == ea_idx)) sample = write_data1;
      if (wr2_ok && (idx2 == ea_idx)) sample = write_data2;
   end

   always_comb begin
      state_d  = state_q;
      fu_ready = 1'b0;
      case (state_q)
         IDLE: begin
            fu_ready = 1'b1;
            if (issue_valid) state_d = EXEC;
         end
         EXEC:    state_d = (op_q == OP_LOAD) ? WAIT : DONE;
         WAIT:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= '0;
         tag_q        <= '0;
         base_q       <= '0;
         off_q        <= '0;
         ea_q         <= '0;
         res_q        <= '0;
         cnt_q        <= '0;
         load_oob_q   <= 1'b0;
         result_valid <= 1'b0;
         result_data  <= '0;
         result_tag   <= '0;
         oob_err      <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_valid <= (state_q == DONE);
         oob_err      <= wr_oob || ((state_q == DONE) && load_oob_q);
         if (issue_valid && (state_q != IDLE)) protocol_err <= 1'b1;
         case (state_q)
            IDLE: begin
               if (issue_valid) begin
                  op_q   <= issue_op;
                  tag_q  <= issue_tag;
                  base_q <= issue_inp1;
                  off_q  <= issue_inp2;
               end
            end
            EXEC: begin
               ea_q       <= ea;
               cnt_q      <= CNT_W'(LOAD_LATENCY - 1);
               load_oob_q <= 1'b0;
               res_q      <= (op_q == OP_STORE) ? ea : 32'd0;
               if (!is_ls) protocol_err <= 1'b1;
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  res_q      <= ea_ok ? sample : 32'd0;
                  load_oob_q <= !ea_ok;
               end
            end
            DONE: begin
               result_data <= res_q;
               result_tag  <= tag_q;
            end
            default: ;
         endcase
      end
   end

   // The array has no reset so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr1_ok) mem[idx1] <= write_data1;
      if (wr2_ok) mem[idx2] <= write_data2;
   end
endmodule

// File: tb/tb_mem_fu_responder.sv
// tb/tb_mem_fu_responder.sv - directed bench for mem_fu_responder
module tb_mem_fu_responder;
   localparam logic [2:0] LD = 3'd1;
   localparam logic [2:0] ST = 3'd2;
   localparam logic [2:0] BAD = 3'd5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [2:0]  issue_op;
   logic [31:0] issue_inp1, issue_inp2;
   logic [5:0]  issue_tag;
   logic        fu_ready, result_valid;
   logic [31:0] result_data;
   logic [5:0]  result_tag;
   logic [31:0] write_address1, write_data1, write_address2, write_data2;
   logic        we1, we2;
   logic        oob_err, protocol_err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_fu_responder dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_inp1(issue_inp1), .issue_inp2(issue_inp2), .issue_tag(issue_tag),
      .fu_ready(fu_ready), .result_valid(result_valid),
      .result_data(result_data), .result_tag(result_tag),
      .write_address1(write_address1), .write_data1(write_data1), .we1(we1),
      .write_address2(write_address2), .write_data2(write_data2), .we2(we2),
      .oob_err(oob_err), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we1;
      logic        we2;
      logic [31:0] wa1;
      logic [31:0] wd1;
      logic [31:0] wa2;
      logic [31:0] wd2;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  tag;
      logic [31:0] exp_data;
      logic        exp_oob;
      logic        exp_woob;
      int          exp_lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] tag);
      issue_valid = 1'b1;
      issue_op    = op;
      issue_inp1  = a;
      issue_inp2  = b;
      issue_tag   = tag;
      step();
      issue_valid = 1'b0;
   endtask

   task automatic do_write(input logic e1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic e2, input logic [31:0] a2, input logic [31:0] d2);
      we1 = e1; write_address1 = a1; write_data1 = d1;
      we2 = e2; write_address2 = a2; write_data2 = d2;
      step();
      we1 = 1'b0;
      we2 = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (result_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic check_result(input string name, input int base, input int exp_lat,
                               input logic [31:0] exp_data, input logic [5:0] exp_tag,
                               input logic exp_oob);
      int lat;
      wait_result(lat);
      check({name, "_lat"}, (lat == 0) ? 32'd0 : 32'(lat + base), 32'(exp_lat));
      check({name, "_data"}, result_data, exp_data);
      check({name, "_tag"}, 32'(result_tag), 32'(exp_tag));
      check({name, "_oob"}, 32'(oob_err), 32'(exp_oob));
      step();
      check({name, "_pulse"}, 32'(result_valid), 32'd0);
   endtask

   task automatic fwd_load(input string name, input logic e1, input logic [31:0] d1,
                           input logic e2, input logic [31:0] d2, input logic [31:0] exp,
                           input logic [5:0] tag);
      do_issue(LD, 32'h80, 32'h0, tag);
      step();
      step();
      do_write(e1, 32'h80, d1, e2, 32'h80, d2);
      check_result(name, 3, 4, exp, tag, 1'b0);
   endtask

   initial begin
      int pulses;

      rst_n = 1'b0;
      issue_valid = 1'b0; issue_op = '0; issue_inp1 = '0; issue_inp2 = '0; issue_tag = '0;
      we1 = 1'b0; we2 = 1'b0;
      write_address1 = '0; write_data1 = '0; write_address2 = '0; write_data2 = '0;

      vecs[0]  = '{1'b1, 1'b0, 32'h108, 32'h1111_1111, 32'h0, 32'h0, ST, 32'h100, 32'h8, 6'd5, 32'h108, 1'b0, 1'b0, 2};
      vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, LD, 32'h100, 32'h8, 6'd6, 32'h1111_1111, 1'b0, 1'b0, 4};
      vecs[2]  = '{1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 32'h0, LD, 32'h3C, 32'h4, 6'd9, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
      vecs[3]  = '{1'b1, 1'b1, 32'h80, 32'h1, 32'h80, 32'h2, LD, 32'h80, 32'h0, 6'd10, 32'h2, 1'b0, 1'b0, 4};
      vecs[4]  = '{1'b1, 1'b1, 32'h84, 32'hA, 32'h88, 32'hB, LD, 32'h84, 32'h0, 6'd11, 32'hA, 1'b0, 1'b0, 4};
      vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, LD, 32'h80, 32'h8, 6'd12, 32'hB, 1'b0, 1'b0, 4};
      vecs[6]  = '{1'b1, 1'b0, 32'hFFC, 32'hCAFE_F00D, 32'h0, 32'h0, LD, 32'h1000, 32'h0, 6'd13, 32'h0, 1'b1, 1'b0, 4};
      vecs[7]  = '{1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h1234_5678, LD, 32'hFF8, 32'h4, 6'd14, 32'hCAFE_F00D, 1'b0, 1'b1, 4};
      vecs[8]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, LD, 32'hFFFF_FFFC, 32'h44, 6'd15, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
      vecs[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, LD, 32'h41, 32'h2, 6'd16, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
      vecs[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ST, 32'hFFFF_FFF0, 32'h20, 6'd63, 32'h10, 1'b0, 1'b0, 2};

      step();
      step();
      check("rst_fu_ready", 32'(fu_ready), 32'd1);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_result_data", result_data, 32'd0);
      check("rst_result_tag", 32'(result_tag), 32'd0);
      check("rst_oob", 32'(oob_err), 32'd0);
      check("rst_protocol", 32'(protocol_err), 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].we1 || vecs[i].we2) begin
            do_write(vecs[i].we1, vecs[i].wa1, vecs[i].wd1, vecs[i].we2, vecs[i].wa2, vecs[i].wd2);
            check($sformatf("v%0d_woob", i), 32'(oob_err), 32'(vecs[i].exp_woob));
         end
         do_issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
         check($sformatf("v%0d_busy", i), 32'(fu_ready), 32'd0);
         check_result($sformatf("v%0d", i), 0, vecs[i].exp_lat, vecs[i].exp_data,
                      vecs[i].tag, vecs[i].exp_oob);
      end

      // Retire writes landing in the load sample cycle.
      fwd_load("fwd_p1", 1'b1, 32'h55, 1'b0, 32'h0, 32'h55, 6'd20);
      fwd_load("fwd_p2", 1'b1, 32'h77, 1'b1, 32'h99, 32'h99, 6'd21);
      check("no_protocol_yet", 32'(protocol_err), 32'd0);

      // Issue attempted while the unit is waiting on a load.
      do_issue(LD, 32'h40, 32'h0, 6'd22);
      step();
      do_issue(ST, 32'h200, 32'h0, 6'd23);
      check("busy_protocol", 32'(protocol_err), 32'd1);
      check_result("busy_load", 2, 4, 32'hDEAD_BEEF, 6'd22, 1'b0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (result_valid) pulses++;
      end
      check("busy_ignored", 32'(pulses), 32'd0);
      check("busy_sticky", 32'(protocol_err), 32'd1);

      // Reset while a load is in WAIT.
      do_issue(LD, 32'h40, 32'h0, 6'd24);
      step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", 32'(fu_ready), 32'd1);
      check("rst_mid_valid", 32'(result_valid), 32'd0);
      check("rst_mid_protocol", 32'(protocol_err), 32'd0);
      step();
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (result_valid) pulses++;
      end
      check("rst_mid_no_late", 32'(pulses), 32'd0);
      do_issue(LD, 32'h40, 32'h0, 6'd25);
      check_result("rst_mem_kept", 0, 4, 32'hDEAD_BEEF, 6'd25, 1'b0);

      // Non load/store opcode.
      do_issue(BAD, 32'h40, 32'h0, 6'd26);
      check_result("bad_op", 0, 2, 32'h0, 6'd26, 1'b0);
      check("bad_op_protocol", 32'(protocol_err), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_fu_responder.md
Name: mem_fu_responder

Overview:
- Memory-side responder for functional-unit slot 2, the load/store FU fed by the reservation station.
- Accepts one issued load/store operation, computes the effective address and returns a tagged result.
- Loads return memory data after a fixed latency; stores return their address for the ROB.
- Owns the data memory array and services the two in-order retire store write ports.

Parameters:
- MEM_WORDS, 1024, depth of the 32-bit word memory; byte address range is 0 to 4*MEM_WORDS-1.
- LOAD_LATENCY, 2, wait cycles between address computation and the load data sample (minimum 1).
- TAG_W, 6, width of the ROB tag carried with each operation.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  an operation is presented this cycle.
- issue_op  in  3  operation code; load and store encodings come from operationList.
- issue_inp1  in  32  base register value.
- issue_inp2  in  32  immediate offset.
- issue_tag  in  TAG_W  ROB row of the operation.
- fu_ready  out  1  high when idle and able to accept an issue.
- result_valid  out  1  one-cycle pulse; result_data and result_tag are valid.
- result_data  out  32  load data, or store effective address.
- result_tag  out  TAG_W  echo of the issue_tag of the completing operation.
- write_address1  in  32  retire store port 1, older store.
- write_data1  in  32  data for port 1.
- we1  in  1  write enable for port 1.
- write_address2  in  32  retire store port 2, younger store.
- write_data2  in  32  data for port 2.
- we2  in  1  write enable for port 2.
- oob_err  out  1  one-cycle pulse on any out-of-range access.
- protocol_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values (asynchronous): state=IDLE, fu_ready=1, result_valid=0, result_data=0, result_tag=0, oob_err=0, protocol_err=0.
- Reset does not clear the memory array.
- Reset asserted mid-operation drops the in-flight operation; no result is produced.
- Effective address is issue_inp1+issue_inp2, modulo 2^32.
- Word index is ea[31:2]; ea[1:0] is ignored, so all accesses are word accesses.
- An address is in range when ea < 4*MEM_WORDS.
- The address, op and tag are registered at issue.
- States and transitions:
  - IDLE: fu_ready=1. When issue_valid=1, capture the operation and go to EXEC.
  - EXEC: compute ea. Store, or any op other than load/store, goes to DONE. Load loads a counter with LOAD_LATENCY-1 and goes to WAIT.
  - WAIT: decrement the counter. When the counter is 0, sample memory into the result register and go to DONE.
  - DONE: result_valid=1 for exactly one cycle, then go to IDLE.
- fu_ready is low in every state except IDLE.
- Latency from the issue edge:
  - Store: result_valid 2 cycles after issue.
  - Load: result_valid LOAD_LATENCY+2 cycles after issue.
- Back-to-back issue is allowed in the cycle DONE returns to IDLE.
- issue_valid=1 while fu_ready=0 sets protocol_err and the issue is ignored.
- Store result is ea.
- Load result is mem[ea[31:2]]; out-of-range loads return 0 and pulse oob_err in the DONE cycle.
- Non-load/store op returns result_data=0 and sets protocol_err.
- Retire writes are processed independently of the FSM, every cycle.
  - Port 1 writes when we1=1; port 2 writes when we2=1.
  - Same word on both ports: port 2 data wins.
  - Out-of-range write: dropped, and oob_err pulses in the following cycle.
- Load sample in the same cycle as a retire write to the same word returns the newly written data (write-first forwarding, port 2 priority).
- Stores never write memory from the issue path; memory is written only through the retire ports.

Test Plan:
1. Reset then store: issue store inp1=0x100, inp2=0x8, tag=5 -> 2 cycles later result_valid=1, data=0x108, tag=5; memory unchanged; fu_ready low for 2 cycles.
2. Write then load: we1, addr=0x40, data=0xDEADBEEF; next cycle issue load inp1=0x3C, inp2=4, tag=9 -> result 0xDEADBEEF, tag 9, 4 cycles after issue (LOAD_LATENCY=2).
3. Dual-port collision and forwarding:
   - we1 and we2 both to 0x80, data 1 and 2 -> a later load of 0x80 returns 2.
   - A write of 0x55 landing in the load sample cycle -> load returns 0x55.
4. Busy issue: second issue_valid asserted during WAIT -> ignored, protocol_err=1 and stays 1; first load completes normally.
5. Out of range: load at 4*MEM_WORDS -> result 0 with oob_err pulse; we2 to 0xFFFFFFFC -> dropped, oob_err pulse, no array change.
6. Reset mid-WAIT: rst_n low during WAIT -> fu_ready=1 and result_valid=0 immediately, no late result; earlier memory contents preserved.
